// File: rtl/isp_bus_pkg.sv
// Shared defaults and types for the ISP frame bus.
package isp_bus_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 256;
  localparam int USEDW_W    = 9;
  localparam int MEM_DEPTH  = 1024;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/isp_frame_bus_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data, full/empty
// flags and an occupancy count that holds 0..DEPTH.
module sync_fifo #(
  parameter int DATA_W  = isp_bus_pkg::DATA_W,
  parameter int DEPTH   = isp_bus_pkg::FIFO_DEPTH,
  parameter int USEDW_W = isp_bus_pkg::USEDW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [USEDW_W-1:0] usedw
);
  import isp_bus_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [USEDW_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  // A push into a full FIFO is discarded; a pop from an empty one is ignored.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == USEDW_W'(DEPTH));
  assign empty    = (count == '0);
  assign usedw    = count;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/isp_frame_bus.sv
// ISP frame bus: write FIFO -> frame buffer RAM -> read FIFO -> oData.
// Optional macro ISP_BUS_OVALID_EN adds the oValid output strobe.
module isp_frame_bus #(
  parameter int DATA_W     = isp_bus_pkg::DATA_W,
  parameter int FIFO_DEPTH = isp_bus_pkg::FIFO_DEPTH,
  parameter int USEDW_W    = isp_bus_pkg::USEDW_W,
  parameter int MEM_DEPTH  = isp_bus_pkg::MEM_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  iData,
  input  logic               iValid,
  input  logic               read_init,
  output logic [DATA_W-1:0]  oData,
`ifdef ISP_BUS_OVALID_EN
  output logic               oValid,
`endif
  output logic               read_empty_rdfifo,
  output logic               write_full_wrfifo,
  output logic [USEDW_W-1:0] write_fifo_wrusedw,
  output logic [USEDW_W-1:0] write_fifo_rdusedw,
  output logic [USEDW_W-1:0] read_fifo_wrusedw,
  output logic [USEDW_W-1:0] read_fifo_rdusedw
);
  import isp_bus_pkg::*;

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0]  wf_data;
  logic               wf_full;
  logic               wf_empty;
  logic [USEDW_W-1:0] wf_usedw;

  logic [DATA_W-1:0]  rf_data;
  logic               rf_full;
  logic               rf_empty;
  logic [USEDW_W-1:0] rf_usedw;

  logic [DATA_W-1:0]  ram [MEM_DEPTH];
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [CNT_W-1:0]   ram_cnt;

  logic [DATA_W-1:0]  ram_q_p1;
  logic               vld_p1;

  logic               wr_mv;
  logic               rd_mv;
  logic               out_pop;
  logic [USEDW_W:0]   rf_commit;

  // Write-side FIFO fed straight from the capture interface.
  sync_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (FIFO_DEPTH),
    .USEDW_W (USEDW_W)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (iValid),
    .push_data (iData),
    .pop       (wr_mv),
    .pop_data  (wf_data),
    .full      (wf_full),
    .empty     (wf_empty),
    .usedw     (wf_usedw)
  );

  // Read-side FIFO fed by the registered RAM read.
  sync_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (FIFO_DEPTH),
    .USEDW_W (USEDW_W)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (vld_p1),
    .push_data (ram_q_p1),
    .pop       (out_pop),
    .pop_data  (rf_data),
    .full      (rf_full),
    .empty     (rf_empty),
    .usedw     (rf_usedw)
  );

  // Read FIFO space already promised: stored words plus the read in flight.
  assign rf_commit = {1'b0, rf_usedw} + (USEDW_W+1)'(vld_p1);

  // The write mover never writes when the RAM is full, so whenever a read is
  // issued (count > 0) its address differs from the concurrent write address.
  assign wr_mv   = !wf_empty && (ram_cnt < CNT_W'(MEM_DEPTH));
  assign rd_mv   = read_init && (ram_cnt != '0) && !rf_full &&
                   (rf_commit < (USEDW_W+1)'(FIFO_DEPTH));
  assign out_pop = read_init && !rf_empty;

  // RAM pointers, word count and the read-in-flight flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
      rd_addr <= '0;
      ram_cnt <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (wr_mv) wr_addr <= wr_addr + 1'b1;
      if (rd_mv) rd_addr <= rd_addr + 1'b1;
      case ({wr_mv, rd_mv})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      vld_p1 <= rd_mv;
    end
  end

  // Stage p1: frame buffer write and registered read (one-cycle latency).
  always_ff @(posedge clk) begin
    if (wr_mv) ram[wr_addr] <= wf_data;
    if (rd_mv) ram_q_p1 <= ram[rd_addr];
  end

  // Output register: takes the read FIFO head when the consumer asks for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oData <= '0;
    end else if (out_pop) begin
      oData <= rf_data;
    end
  end

`ifdef ISP_BUS_OVALID_EN
  // Strobe marking the cycle after each pop into oData.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oValid <= 1'b0;
    end else begin
      oValid <= out_pop;
    end
  end
`endif

  assign read_empty_rdfifo  = rf_empty;
  assign write_full_wrfifo  = wf_full;
  assign write_fifo_wrusedw = wf_usedw;
  assign write_fifo_rdusedw = wf_usedw;
  assign read_fifo_wrusedw  = rf_usedw;
  assign read_fifo_rdusedw  = rf_usedw;

endmodule

// File: tb/tb_isp_frame_bus.sv
// Testbench for isp_frame_bus: a vector table for reset/latency/empty-read,
// then directed and random streams checked against a queue-level model.
module tb_isp_frame_bus;
  import isp_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  word_t       iData;
  logic        iValid;
  logic        read_init;
  word_t       oData;
`ifdef ISP_BUS_OVALID_EN
  logic        oValid;
`endif
  logic        read_empty_rdfifo;
  logic        write_full_wrfifo;
  logic [8:0]  write_fifo_wrusedw;
  logic [8:0]  write_fifo_rdusedw;
  logic [8:0]  read_fifo_wrusedw;
  logic [8:0]  read_fifo_rdusedw;

  always #5 clk = ~clk;

  isp_frame_bus dut (
    .clk                (clk),
    .reset              (reset),
    .iData              (iData),
    .iValid             (iValid),
    .read_init          (read_init),
    .oData              (oData),
`ifdef ISP_BUS_OVALID_EN
    .oValid             (oValid),
`endif
    .read_empty_rdfifo  (read_empty_rdfifo),
    .write_full_wrfifo  (write_full_wrfifo),
    .write_fifo_wrusedw (write_fifo_wrusedw),
    .write_fifo_rdusedw (write_fifo_rdusedw),
    .read_fifo_wrusedw  (read_fifo_wrusedw),
    .read_fifo_rdusedw  (read_fifo_rdusedw)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: words held in each buffer ----------
  word_t wq[$];
  word_t ramq[$];
  word_t rq[$];
  bit    pv;
  word_t pd;
  word_t m_odata;
  bit    m_ovalid;
  int    pop_cnt;
  word_t last_pop;
  int    max_rf;

  task automatic model_reset();
    wq.delete();
    ramq.delete();
    rq.delete();
    pv       = 1'b0;
    pd       = '0;
    m_odata  = '0;
    m_ovalid = 1'b0;
    pop_cnt  = 0;
    last_pop = '0;
  endtask

  task automatic check_model();
    chk("oData", oData, m_odata);
    chk("rd_empty", 32'(read_empty_rdfifo), 32'(rq.size() == 0));
    chk("wr_full", 32'(write_full_wrfifo), 32'(wq.size() == 256));
    chk("wf_wrusedw", 32'(write_fifo_wrusedw), 32'(wq.size()));
    chk("wf_rdusedw", 32'(write_fifo_rdusedw), 32'(wq.size()));
    chk("rf_wrusedw", 32'(read_fifo_wrusedw), 32'(rq.size()));
    chk("rf_rdusedw", 32'(read_fifo_rdusedw), 32'(rq.size()));
`ifdef ISP_BUS_OVALID_EN
    chk("oValid", 32'(oValid), 32'(m_ovalid));
`endif
    if (int'(read_fifo_rdusedw) > max_rf) max_rf = int'(read_fifo_rdusedw);
  endtask

  // One clock: drive inputs, advance the model by the buffer rules, compare.
  task automatic step(input bit v, input word_t d, input bit ri);
    bit opop, rd, wmv, psh;
    iValid    = v;
    iData     = d;
    read_init = ri;
    opop = ri && (rq.size() > 0);
    rd   = ri && (ramq.size() > 0) && ((rq.size() + (pv ? 1 : 0)) < 256);
    wmv  = (wq.size() > 0) && (ramq.size() < 1024);
    psh  = v && (wq.size() < 256);
    @(posedge clk);
    if (opop) begin
      m_odata  = rq.pop_front();
      pop_cnt++;
      last_pop = m_odata;
    end
    m_ovalid = opop;
    if (pv) rq.push_back(pd);
    if (rd) begin
      pd = ramq.pop_front();
      pv = 1'b1;
    end else begin
      pv = 1'b0;
    end
    if (wmv) ramq.push_back(wq.pop_front());
    if (psh) wq.push_back(d);
    #1;
    check_model();
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    iValid    = 1'b0;
    iData     = '0;
    read_init = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_oData", oData, 32'h0);
    chk("rst_empty", 32'(read_empty_rdfifo), 32'h1);
    chk("rst_full", 32'(write_full_wrfifo), 32'h0);
    chk("rst_wf_wr", 32'(write_fifo_wrusedw), 32'h0);
    chk("rst_wf_rd", 32'(write_fifo_rdusedw), 32'h0);
    chk("rst_rf_wr", 32'(read_fifo_wrusedw), 32'h0);
    chk("rst_rf_rd", 32'(read_fifo_rdusedw), 32'h0);
`ifdef ISP_BUS_OVALID_EN
    chk("rst_oValid", 32'(oValid), 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ------------------------------------------
  typedef struct {
    bit    v;
    word_t d;
    bit    ri;
    word_t e_odata;
    bit    e_empty;
    int    e_wf;
    int    e_rf;
    bit    e_ovalid;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    reset     = 1'b1;
    iValid    = 1'b0;
    iData     = '0;
    read_init = 1'b0;
    max_rf    = 0;
    model_reset();

    // Empty read, then a single word through the full path with read_init high.
    tbl[0] = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 0, 0, 1'b0};
    tbl[1] = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 0, 0, 1'b0};
    tbl[2] = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 0, 0, 1'b0};
    tbl[3] = '{1'b1, 32'hA5A5_0001, 1'b1, 32'h0,         1'b1, 1, 0, 1'b0};
    tbl[4] = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 0, 0, 1'b0};
    tbl[5] = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 0, 0, 1'b0};
    tbl[6] = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 0, 1, 1'b0};
    tbl[7] = '{1'b0, 32'h0,         1'b1, 32'hA5A5_0001, 1'b1, 0, 0, 1'b1};
    tbl[8] = '{1'b0, 32'h0,         1'b1, 32'hA5A5_0001, 1'b1, 0, 0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("init_oData", oData, 32'h0);
    chk("init_empty", 32'(read_empty_rdfifo), 32'h1);

    for (int i = 0; i < 9; i++) begin
      iValid    = tbl[i].v;
      iData     = tbl[i].d;
      read_init = tbl[i].ri;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_oData", i), oData, tbl[i].e_odata);
      chk($sformatf("tbl%0d_empty", i), 32'(read_empty_rdfifo), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_wf", i), 32'(write_fifo_wrusedw), 32'(tbl[i].e_wf));
      chk($sformatf("tbl%0d_rf", i), 32'(read_fifo_rdusedw), 32'(tbl[i].e_rf));
`ifdef ISP_BUS_OVALID_EN
      chk($sformatf("tbl%0d_oValid", i), 32'(oValid), 32'(tbl[i].e_ovalid));
`endif
    end

    // Basic stream 1..640, consumer joins at word 100.
    do_reset();
    for (int i = 1; i <= 640; i++) step(1'b1, word_t'(i), i >= 100);
    for (int i = 0; i < 200; i++) step(1'b0, '0, 1'b1);
    chk("stream_last", last_pop, 32'd640);
    chk("stream_count", 32'(pop_cnt), 32'd640);

    // Mid-stream reset discards buffered words.
    for (int i = 1; i <= 20; i++) step(1'b1, word_t'(32'hBEEF_0000 + i), 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    chk("post_rst_pops", 32'(pop_cnt), 32'd0);

    // Fill RAM and write FIFO, overflow by one word, then drain.
    for (int i = 1; i <= 1280; i++) step(1'b1, word_t'(i), 1'b0);
    chk("full_flag", 32'(write_full_wrfifo), 32'h1);
    chk("full_usedw", 32'(write_fifo_wrusedw), 32'd256);
    step(1'b1, word_t'(1281), 1'b0);
    budget = 0;
    while ((wq.size() + ramq.size() + rq.size() + (pv ? 1 : 0)) != 0 && budget < 3000) begin
      step(1'b0, '0, 1'b1);
      budget++;
    end
    chk("drain_done", 32'(budget < 3000), 32'h1);
    chk("drain_last", last_pop, 32'd1280);
    chk("drain_count", 32'(pop_cnt), 32'd1280);

    // read_init toggling every cycle over 300 words.
    do_reset();
    max_rf = 0;
    for (int i = 1; i <= 300; i++) step(1'b1, word_t'(32'h7000_0000 + i), i[0]);
    for (int i = 0; i < 800; i++) step(1'b0, '0, i[0]);
    chk("toggle_count", 32'(pop_cnt), 32'd300);
    chk("toggle_last", last_pop, 32'h7000_012C);
    chk("toggle_rf_max_ok", 32'(max_rf <= 256), 32'h1);

    // Random traffic with random consumer behaviour.
    do_reset();
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 7, word_t'($urandom), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 1400; i++) step(1'b0, '0, 1'b1);
    chk("rand_empty_end", 32'(read_empty_rdfifo), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/isp_frame_bus.md
Name: isp_frame_bus

Overview:
- Single-clock streaming buffer between the ISP capture side and the display/consumer side.
- Path: 32-bit input words → write FIFO → frame buffer RAM → read FIFO → oData.
- The consumer controls draining with read_init.
- FIFO fill levels and full/empty flags are exported for debug and flow monitoring.

Parameters:
- DATA_W, 32, word width of iData/oData.
- FIFO_DEPTH, 256, entries in each of the write and read FIFOs (power of 2).
- USEDW_W, 9, width of the usedw outputs; holds 0..FIFO_DEPTH.
- MEM_DEPTH, 1024, frame buffer RAM words (power of 2).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- iData  in  DATA_W  input pixel word.
- iValid  in  1  iData is valid this cycle.
- read_init  in  1  consumer request; while high, one word per cycle is drained to oData.
- oData  out  DATA_W  output word; registered.
- read_empty_rdfifo  out  1  read FIFO is empty.
- write_full_wrfifo  out  1  write FIFO is full.
- write_fifo_wrusedw  out  USEDW_W  write FIFO occupancy.
- write_fifo_rdusedw  out  USEDW_W  write FIFO occupancy; identical to wrusedw.
- read_fifo_wrusedw  out  USEDW_W  read FIFO occupancy.
- read_fifo_rdusedw  out  USEDW_W  read FIFO occupancy; identical to wrusedw.

Behaviour:
- Reset (asynchronous, active-high):
  - All FIFO pointers, the RAM pointers and the RAM word count clear.
  - oData = 0, all usedw = 0, read_empty_rdfifo = 1, write_full_wrfifo = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-stream discards all buffered data.
- Write side:
  - iValid=1 and write FIFO not full → iData is pushed at that edge.
  - iValid=1 and write FIFO full → the word is dropped silently; FIFO state is unchanged.
- Write mover:
  - Each cycle, if the write FIFO is non-empty and RAM count < MEM_DEPTH, pop one word and write it to RAM[wr_ptr].
  - wr_ptr increments and wraps at MEM_DEPTH.
  - The mover runs regardless of read_init.
- Read mover:
  - Each cycle, if read_init=1, RAM count > 0, and read FIFO occupancy plus in-flight reads < FIFO_DEPTH, read RAM[rd_ptr].
  - The RAM read is registered with 1-cycle latency; the data is pushed into the read FIFO on the next edge.
  - rd_ptr wraps at MEM_DEPTH.
- RAM count:
  - +1 on write, −1 on read; simultaneous write and read leaves it unchanged.
  - A write and a read to the same address in the same cycle must not return stale data: bypass, or guarantee the read is only issued when count > 0 before the write.
- Output:
  - If read_init=1 and the read FIFO is non-empty, pop one word into the oData register.
  - Otherwise oData holds its value; read_init on an empty read FIFO has no effect.
- Latency: with everything empty and read_init held high, a word accepted at edge N appears on oData after edge N+4. The path is write FIFO (N) → RAM write (N+1) → RAM read (N+2) → read FIFO push (N+3) → oData (N+4).
- Throughput: with read_init high and no stalls, 1 word per cycle.
- Ordering: strictly FIFO end to end; no duplication or loss except drops at write_full_wrfifo.
- usedw: reflects occupancy after each edge; the write-side and read-side copies are equal (single clock).
- Simultaneous push and pop on either FIFO: occupancy unchanged, both succeed.

Optional Feature:
- ISP_BUS_OVALID_EN defined: adds output oValid (1 bit). It is registered high for exactly the cycle after each pop into oData, low otherwise, and 0 in reset.
- ISP_BUS_OVALID_EN undefined: port absent; all other behaviour is identical.

Decomposition:
- Package isp_bus_pkg: DATA_W, FIFO_DEPTH, USEDW_W, MEM_DEPTH defaults, and typedef word_t (logic [DATA_W-1:0]).
- One sub-module, sync_fifo: parameterised single-clock FIFO with first-word-fall-through read, full, empty and usedw. It is instantiated twice (write side and read side).
- The movers and RAM stay in the top module.

Test Plan:
- Reset: assert reset mid-cycle → all usedw=0, read_empty_rdfifo=1, write_full_wrfifo=0, oData=0 immediately.
- Basic stream: after reset, drive iValid=1 with iData=1..640 over consecutive cycles; raise read_init from word 100 and hold it for 200 further cycles after iValid drops → oData presents 1,2,3,… in order, one per cycle, with no gaps once flowing.
- Latency: write a single word 0xA5A5_0001 with read_init already high → oData=0xA5A5_0001 exactly 4 edges after acceptance.
- Write FIFO full: read_init=0 and MEM_DEPTH filled (1024 words), then 256 more → write_full_wrfifo=1 and write_fifo_wrusedw=256. A 1281st word is dropped; after draining, the output sequence ends at word 1280.
- Read FIFO back-pressure: read_init toggles 1/0 every cycle over 300 words → no loss or reorder; read_fifo_rdusedw never exceeds 256.
- Empty read: read_init=1 with nothing written → oData stays 0 and read_empty_rdfifo stays 1; with ISP_BUS_OVALID_EN, oValid stays 0.
